// File: rtl/conv_pkg.sv
// conv_pkg: shared types, FSM state encoding and output clamp for the 3x3 frame scheduler
//   state_t : IDLE, FETCH, EXEC, WRITE, DONE
//   pixel_t : 8-bit unsigned pixel
//   win_t   : 9-bit signed window tap (pixel zero-extended)
//   acc_t   : 17-bit signed engine result
//   sat_u8  : clamps an acc_t into 0..255
package conv_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, WRITE, DONE} state_t;

    typedef logic [7:0]         pixel_t;
    typedef logic signed [8:0]  win_t;
    typedef logic signed [16:0] acc_t;

    function automatic pixel_t sat_u8(acc_t a);
        return a < 17'sd0 ? 8'd0 : a > 17'sd255 ? 8'hff : a[7:0];
    endfunction

endpackage

// File: rtl/conv3x3_frame_scheduler_if.sv
// conv3x3_frame_scheduler_if: bundles the source-read, engine and destination-write signals
//   src_rd_en / src_rd_addr / src_rd_data : source frame buffer read port (data one cycle after enable)
//   win / conv_out                        : 3x3 window to the engine and its 17-bit result
//   dst_wr_en / dst_wr_addr / dst_wr_data / dst_wr_ready : destination write with ready handshake
//   master : scheduler side, slave : buffers + engine side
interface conv3x3_frame_scheduler_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = 12
);

    logic              src_rd_en;
    logic [ADDR_W-1:0] src_rd_addr;
    pixel_t            src_rd_data;

    win_t              win [0:2][0:2];
    acc_t              conv_out;

    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_wr_addr;
    pixel_t            dst_wr_data;
    logic              dst_wr_ready;

    modport master (
        output src_rd_en, src_rd_addr, win, dst_wr_en, dst_wr_addr, dst_wr_data,
        input  src_rd_data, conv_out, dst_wr_ready
    );

    modport slave (
        input  src_rd_en, src_rd_addr, win, dst_wr_en, dst_wr_addr, dst_wr_data,
        output src_rd_data, conv_out, dst_wr_ready
    );

endinterface

// File: rtl/conv3x3_tap_gen.sv
// conv3x3_tap_gen: maps output pixel (x, y) and tap index k to the source address and an in-frame flag
//   i_x, i_y    : output pixel coordinates
//   i_k         : tap index 0..8, row = k/3, col = k%3, offset (-1..+1) from (x, y)
//   o_addr      : row-major source address of the tap (meaningful only when o_in_range)
//   o_in_range  : tap lies inside the frame and k is a valid tap index
module conv3x3_tap_gen #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H),
    parameter int XW     = $clog2(IMG_W),
    parameter int YW     = $clog2(IMG_H)
) (
    input  logic [XW-1:0]     i_x,
    input  logic [YW-1:0]     i_y,
    input  logic [3:0]        i_k,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_range
);

    int w_tx;
    int w_ty;

    always_comb begin
        w_ty       = int'(i_y) + int'(i_k) / 3 - 1;
        w_tx       = int'(i_x) + int'(i_k) % 3 - 1;
        o_in_range = i_k < 4'd9 && w_tx >= 0 && w_tx < IMG_W && w_ty >= 0 && w_ty < IMG_H;
        o_addr     = ADDR_W'(w_ty * IMG_W + w_tx);
    end

endmodule

// File: rtl/conv3x3_frame_scheduler.sv
// conv3x3_frame_scheduler: walks a WxH frame, gathers zero-padded 3x3 windows for the conv engine,
// clamps each result to 0..255 and writes it to the destination buffer.
//   clk, rst : clock and synchronous active-high reset
//   start    : one-cycle pulse, accepted only in IDLE
//   busy     : high from the cycle after an accepted start through the DONE cycle
//   done     : one-cycle pulse after the last pixel write is accepted
//   bus      : master side of conv3x3_frame_scheduler_if (source read, window/result, destination write)
module conv3x3_frame_scheduler
    import conv_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int CONV_LAT = 1,
    parameter int ADDR_W   = $clog2(IMG_W * IMG_H)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    conv3x3_frame_scheduler_if.master bus
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int LW = $clog2(CONV_LAT + 1);

    state_t            r_state;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [3:0]        r_c;
    logic [LW-1:0]     r_e;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic              r_rd_q;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    pixel_t            r_wr_data;
    win_t              r_win [0:8];

    logic [XW-1:0]     w_nx;
    logic [YW-1:0]     w_ny;
    logic [XW-1:0]     w_tx;
    logic [YW-1:0]     w_ty;
    logic [3:0]        w_k;
    logic              w_last;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;

    // The read strobe is registered, so the tap generator looks one cycle ahead:
    // tap 0 of the next pixel while leaving IDLE/WRITE, tap c+1 while in FETCH cycle c.
    always_comb begin
        w_last = r_x == XW'(IMG_W - 1) && r_y == YW'(IMG_H - 1);
        w_nx   = r_x == XW'(IMG_W - 1) ? '0 : r_x + 1'b1;
        w_ny   = r_x == XW'(IMG_W - 1) ? r_y + 1'b1 : r_y;
        w_tx   = r_state == FETCH ? r_x : r_state == WRITE ? w_nx : '0;
        w_ty   = r_state == FETCH ? r_y : r_state == WRITE ? w_ny : '0;
        w_k    = r_state == FETCH ? r_c + 4'd1 : 4'd0;
    end

    conv3x3_tap_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .XW     (XW),
        .YW     (YW)
    ) u_tap_gen (
        .i_x        (w_tx),
        .i_y        (w_ty),
        .i_k        (w_k),
        .o_addr     (w_addr),
        .o_in_range (w_in_range)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_c       <= '0;
            r_e       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_q    <= 1'b0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
        end else begin
            // r_rd_q remembers whether the tap issued last cycle was really read or padded
            r_rd_q <= r_rd_en;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_c     <= '0;
                        r_busy  <= 1'b1;
                        r_rd_en <= w_in_range;
                        if (w_in_range) r_rd_addr <= w_addr;
                    end
                end
                FETCH: begin
                    if (r_c != 4'd0) r_win[r_c - 4'd1] <= r_rd_q ? {1'b0, bus.src_rd_data} : '0;
                    r_rd_en <= w_in_range;
                    if (w_in_range) r_rd_addr <= w_addr;
                    r_c <= r_c + 4'd1;
                    if (r_c == 4'd9) begin
                        r_state <= EXEC;
                        r_e     <= '0;
                    end
                end
                EXEC: begin
                    r_e <= r_e + 1'b1;
                    if (r_e == LW'(CONV_LAT)) begin
                        r_state   <= WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= ADDR_W'(int'(r_y) * IMG_W + int'(r_x));
                        r_wr_data <= sat_u8(bus.conv_out);
                    end
                end
                WRITE: begin
                    if (bus.dst_wr_ready) begin
                        r_wr_en <= 1'b0;
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                            r_x     <= w_nx;
                            r_y     <= w_ny;
                            r_c     <= '0;
                            r_rd_en <= w_in_range;
                            if (w_in_range) r_rd_addr <= w_addr;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign bus.src_rd_en   = r_rd_en;
    assign bus.src_rd_addr = r_rd_addr;
    assign bus.dst_wr_en   = r_wr_en;
    assign bus.dst_wr_addr = r_wr_addr;
    assign bus.dst_wr_data = r_wr_data;

    for (genvar r = 0; r < 3; r++) begin : g_r
        for (genvar c = 0; c < 3; c++) begin : g_c
            assign bus.win[r][c] = r_win[3 * r + c];
        end
    end

endmodule

// File: tb/tb_conv3x3_frame_scheduler.sv
// tb_conv3x3_frame_scheduler: randomized self-checking bench for the 4x4 frame scheduler
module tb_conv3x3_frame_scheduler;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    conv3x3_frame_scheduler_if #(.ADDR_W(4)) bus ();

    conv3x3_frame_scheduler #(
        .IMG_W    (W),
        .IMG_H    (H),
        .CONV_LAT (1),
        .ADDR_W   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int img [N];
    int ker [9];
    int exp_rd [$];
    int exp_wa [$];
    int exp_wd [$];
    int n_chk = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int low_cnt = 0;
    int bp_mode = 0;
    bit hv = 1'b0;
    int ha = 0;
    int hd = 0;

    task automatic chk(string tag, int act, int want);
        n_chk++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, want);
        end
    endtask

    // engine stand-in: one register stage from window to result
    function automatic int eng_sum();
        int s = 0;
        for (int t = 0; t < 9; t++) s += ker[t] * int'(bus.win[t / 3][t % 3]);
        return s;
    endfunction

    always @(posedge clk) bus.conv_out <= acc_t'(eng_sum());
    always @(posedge clk) if (bus.src_rd_en) bus.src_rd_data <= pixel_t'(img[bus.src_rd_addr]);

    // reference: expected read addresses in tap order and clamped writes in raster order
    task automatic build();
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        for (int p = 0; p < N; p++) begin
            int s = 0;
            for (int t = 0; t < 9; t++) begin
                int yy = p / W + t / 3 - 1;
                int xx = p % W + t % 3 - 1;
                if (yy >= 0 && yy < H && xx >= 0 && xx < W) begin
                    exp_rd.push_back(yy * W + xx);
                    s += ker[t] * img[yy * W + xx];
                end
            end
            exp_wa.push_back(p);
            exp_wd.push_back(s < 0 ? 0 : s > 255 ? 255 : s);
        end
    endtask

    initial begin
        bus.dst_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1) begin
                bus.dst_wr_ready = !(bus.dst_wr_en && wr_cnt == 2 && low_cnt < 5);
                if (!bus.dst_wr_ready) low_cnt++;
            end else begin
                bus.dst_wr_ready = bp_mode == 2 ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            hv = 1'b0;
        end else begin
            if (bus.src_rd_en) begin
                if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
                else chk("rd_addr", int'(bus.src_rd_addr), exp_rd.pop_front());
            end
            if (hv) begin
                chk("hold_en", int'(bus.dst_wr_en), 1);
                chk("hold_addr", int'(bus.dst_wr_addr), ha);
                chk("hold_data", int'(bus.dst_wr_data), hd);
            end
            hv = 1'b0;
            if (bus.dst_wr_en) begin
                chk("no_rd_in_wr", int'(bus.src_rd_en), 0);
                if (bus.dst_wr_ready) begin
                    if (exp_wa.size() == 0) chk("wr_extra", 1, 0);
                    else begin
                        chk("wr_addr", int'(bus.dst_wr_addr), exp_wa.pop_front());
                        chk("wr_data", int'(bus.dst_wr_data), exp_wd.pop_front());
                    end
                    wr_cnt++;
                end else begin
                    hv = 1'b1;
                    ha = int'(bus.dst_wr_addr);
                    hd = int'(bus.dst_wr_data);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic run_frame(input bit extra_start);
        int n = 0;
        int d0 = done_cnt;
        bit got = 1'b0;
        build();
        wr_cnt = 0;
        low_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        while (n < 3000 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) start = 1'b0;
            if (extra_start && n == 60) start = 1'b1;
            if (extra_start && n == 61) start = 1'b0;
            @(negedge clk);
            got = done;
        end
        chk("done_seen", int'(got), 1);
        if (bp_mode == 0) chk("frame_cycles", n, N * 13 + 1);
        @(negedge clk);
        chk("busy_after", int'(busy), 0);
        chk("done_once", done_cnt - d0, 1);
        chk("wr_count", wr_cnt, N);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wa.size(), 0);
    endtask

    task automatic set_ramp_identity();
        for (int p = 0; p < N; p++) img[p] = 16 * (p / W) + 4 * (p % W);
        for (int t = 0; t < 9; t++) ker[t] = t == 4 ? 1 : 0;
    endtask

    task automatic set_sharpen(input int center_px);
        for (int p = 0; p < N; p++) img[p] = p == center_px ? 0 : 255;
        for (int t = 0; t < 9; t++) ker[t] = t == 4 ? 5 : t % 2 == 1 ? -1 : 0;
    endtask

    task automatic set_random();
        for (int p = 0; p < N; p++) img[p] = int'($urandom_range(0, 255));
        for (int t = 0; t < 9; t++) ker[t] = int'($urandom_range(0, 8)) - 4;
    endtask

    task automatic mid_reset();
        int n = 0;
        int d0;
        set_random();
        build();
        bp_mode = 0;
        wr_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (n < 500 && !(wr_cnt == 5 && bus.src_rd_en)) begin
            @(negedge clk);
            n++;
        end
        chk("reach_px5", wr_cnt, 5);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_wr_en", int'(bus.dst_wr_en), 0);
        chk("mrst_rd_en", int'(bus.src_rd_en), 0);
        chk("mrst_done", int'(done), 0);
        for (int t = 0; t < 9; t++) chk("mrst_win", int'(bus.win[t / 3][t % 3]), 0);
        rst = 1'b0;
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        repeat (30) @(negedge clk);
        chk("mrst_no_done", done_cnt - d0, 0);
        chk("mrst_idle", int'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(bus.src_rd_en), 0);
        chk("rst_rd_addr", int'(bus.src_rd_addr), 0);
        chk("rst_wr_en", int'(bus.dst_wr_en), 0);
        chk("rst_wr_addr", int'(bus.dst_wr_addr), 0);
        chk("rst_wr_data", int'(bus.dst_wr_data), 0);
        for (int t = 0; t < 9; t++) chk("rst_win", int'(bus.win[t / 3][t % 3]), 0);
        rst = 1'b0;

        set_ramp_identity();
        run_frame(1'b0);

        set_sharpen(-1);
        run_frame(1'b0);

        bp_mode = 1;
        set_sharpen(5);
        run_frame(1'b0);
        chk("bp_low_cycles", low_cnt, 5);

        bp_mode = 2;
        repeat (2) begin
            set_random();
            run_frame(1'b0);
        end

        bp_mode = 0;
        set_random();
        run_frame(1'b1);

        mid_reset();
        set_ramp_identity();
        run_frame(1'b0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("rst_start_idle", int'(busy), 0);
        chk("rst_start_rd", int'(bus.src_rd_en), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
